// File: rtl/mean_frame_ctrl_if.sv
// Bundles the pixel stream, the Mean-stage link and the status/result
// signals of mean_frame_ctrl. The controller connects through the slave
// modport; whatever drives it (upstream source, Mean model, AWB sink)
// uses the master modport.
interface mean_frame_ctrl_if;
  // frame control and status
  logic       start_i;
  logic       abort_i;
  logic [4:0] size_i;
  logic       busy_o;
  logic       done_o;
  logic       err_o;

  // planar pixel stream
  logic       pix_valid_i;
  logic       pix_ready_o;
  logic [7:0] pix_value_i;

  // link to the Mean stage
  logic       mean_rst_n_o;
  logic       mean_valid_o;
  logic [1:0] mean_color_o;
  logic [7:0] mean_value_o;
  logic       mean_last_o;
  logic [4:0] mean_size_o;
  logic       mean_finish_i;
  logic [7:0] r_mean_i;
  logic [7:0] g_mean_i;
  logic [7:0] b_mean_i;

  // captured means handed to AWB
  logic [7:0] r_o;
  logic [7:0] g_o;
  logic [7:0] b_o;

  modport slave (
    input  start_i, abort_i, size_i,
    input  pix_valid_i, pix_value_i,
    input  mean_finish_i, r_mean_i, g_mean_i, b_mean_i,
    output busy_o, done_o, err_o,
    output pix_ready_o,
    output mean_rst_n_o, mean_valid_o, mean_color_o, mean_value_o,
    output mean_last_o, mean_size_o,
    output r_o, g_o, b_o
  );

  modport master (
    output start_i, abort_i, size_i,
    output pix_valid_i, pix_value_i,
    output mean_finish_i, r_mean_i, g_mean_i, b_mean_i,
    input  busy_o, done_o, err_o,
    input  pix_ready_o,
    input  mean_rst_n_o, mean_valid_o, mean_color_o, mean_value_o,
    input  mean_last_o, mean_size_o,
    input  r_o, g_o, b_o
  );
endinterface

// File: rtl/mean_frame_ctrl.sv
// Frame sequencer for the per-colour Mean stage.
// Accepts an R/G/B planar pixel stream, tags each pixel with its colour and
// plane-last flag, flushes Mean between frames through a local reset and
// captures the three means on Mean's finish pulse.
// Optional feature: define MEAN_CTRL_TIMEOUT_EN to add a DRAIN watchdog
// that gives up after TIMEOUT_CYC cycles without a finish pulse.
module mean_frame_ctrl #(
  parameter int SIZE_MAX    = 20,
  parameter int CLR_CYC     = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  mean_frame_ctrl_if.slave bus
);

  // One shared cycle counter times both the CLEAR dwell and the DRAIN
  // watchdog; it is at least 8 bits wide so the watchdog limit always fits.
  localparam int CNT_SPAN  = (CLR_CYC > TIMEOUT_CYC) ? CLR_CYC + 1 : TIMEOUT_CYC + 1;
  localparam int CNT_W_RAW = $clog2(CNT_SPAN);
  localparam int CNT_W     = (CNT_W_RAW < 8) ? 8 : CNT_W_RAW;

  localparam logic [1:0] PLANE_R = 2'd0;
  localparam logic [1:0] PLANE_B = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  state_t           state;
  state_t           next_state;

  logic [4:0]       size_q;
  logic [1:0]       plane_q;
  logic [20:0]      count_q;
  logic [CNT_W-1:0] cyc_cnt_q;
  logic             abort_pend_q;

  logic             mean_rst_n_q;
  logic             mean_valid_q;
  logic [1:0]       mean_color_q;
  logic [7:0]       mean_value_q;
  logic             mean_last_q;
  logic [7:0]       r_q;
  logic [7:0]       g_q;
  logic [7:0]       b_q;
  logic             err_q;

  logic             pix_ready;
  logic             busy;
  logic             done;

  logic             start_ok;
  logic             start_bad;
  logic             abort_hit;
  logic             xfer;
  logic             plane_last;
  logic             clr_done;
  logic             finish_hit;
  logic             timeout_hit;
  logic             cnt_run;

  // Event decode shared by the FSM and the datapath registers.
  always_comb begin
    start_ok   = (state == IDLE) && bus.start_i && (bus.size_i <= 5'(SIZE_MAX));
    start_bad  = (state == IDLE) && bus.start_i && (bus.size_i >  5'(SIZE_MAX));
    abort_hit  = bus.abort_i &&
                 ((state == CLEAR) || (state == STREAM) || (state == DRAIN));
    xfer       = bus.pix_valid_i && pix_ready;
    plane_last = (count_q == ((21'd1 << size_q) - 21'd1));
    clr_done   = (state == CLEAR) && (cyc_cnt_q == CNT_W'(CLR_CYC - 1));
    finish_hit = (state == DRAIN) && bus.mean_finish_i && !bus.abort_i;
`ifdef MEAN_CTRL_TIMEOUT_EN
    timeout_hit = (state == DRAIN) && !bus.mean_finish_i && !bus.abort_i &&
                  (cyc_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    cnt_run     = (state == CLEAR) || (state == DRAIN);
`else
    timeout_hit = 1'b0;
    cnt_run     = (state == CLEAR);
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; abort always routes through CLEAR so Mean is flushed.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start_ok) begin
          next_state = CLEAR;
        end
      end
      CLEAR: begin
        if (abort_hit) begin
          next_state = CLEAR;
        end else if (clr_done) begin
          next_state = abort_pend_q ? IDLE : STREAM;
        end
      end
      STREAM: begin
        if (abort_hit) begin
          next_state = CLEAR;
        end else if (xfer && plane_last && (plane_q == PLANE_B)) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (abort_hit) begin
          next_state = CLEAR;
        end else if (finish_hit) begin
          next_state = DONE;
        end else if (timeout_hit) begin
          next_state = CLEAR;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Moore-style outputs; ready also drops combinationally on an abort.
  always_comb begin
    pix_ready = (state == STREAM) && !bus.abort_i;
    busy      = (state != IDLE);
    done      = (state == DONE);
  end

  // Shared cycle counter, restarted on every state change or abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt_q <= '0;
    end else if ((next_state != state) || abort_hit) begin
      cyc_cnt_q <= '0;
    end else if (cnt_run) begin
      cyc_cnt_q <= cyc_cnt_q + CNT_W'(1);
    end
  end

  // Remembers that the current CLEAR pass ends in IDLE rather than STREAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abort_pend_q <= 1'b0;
    end else if (start_ok) begin
      abort_pend_q <= 1'b0;
    end else if (abort_hit || timeout_hit) begin
      abort_pend_q <= 1'b1;
    end else if (clr_done) begin
      abort_pend_q <= 1'b0;
    end
  end

  // Frame size latched on an accepted start and forwarded to Mean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_q <= '0;
    end else if (start_ok) begin
      size_q <= bus.size_i;
    end
  end

  // Plane and pixel-in-plane tracking; rewound while Mean is being cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      plane_q <= PLANE_R;
      count_q <= '0;
    end else if (state == CLEAR) begin
      plane_q <= PLANE_R;
      count_q <= '0;
    end else if (xfer) begin
      if (plane_last) begin
        count_q <= '0;
        plane_q <= (plane_q == PLANE_B) ? PLANE_R : plane_q + 2'd1;
      end else begin
        count_q <= count_q + 21'd1;
      end
    end
  end

  // Mean's local reset is low for exactly the cycles spent in CLEAR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mean_rst_n_q <= 1'b0;
    end else begin
      mean_rst_n_q <= (next_state != CLEAR);
    end
  end

  // Each accepted pixel is forwarded to Mean one cycle later with its tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mean_valid_q <= 1'b0;
      mean_color_q <= '0;
      mean_value_q <= '0;
      mean_last_q  <= 1'b0;
    end else begin
      mean_valid_q <= xfer;
      mean_last_q  <= xfer && plane_last;
      if (xfer) begin
        mean_color_q <= plane_q;
        mean_value_q <= bus.pix_value_i;
      end
    end
  end

  // Means are captured only on a finish pulse that arrives in DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else if (finish_hit) begin
      r_q <= bus.r_mean_i;
      g_q <= bus.g_mean_i;
      b_q <= bus.b_mean_i;
    end
  end

  // Error pulse for a rejected start or an expired DRAIN watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= start_bad || timeout_hit;
    end
  end

  assign bus.pix_ready_o  = pix_ready;
  assign bus.busy_o       = busy;
  assign bus.done_o       = done;
  assign bus.err_o        = err_q;
  assign bus.mean_rst_n_o = mean_rst_n_q;
  assign bus.mean_valid_o = mean_valid_q;
  assign bus.mean_color_o = mean_color_q;
  assign bus.mean_value_o = mean_value_q;
  assign bus.mean_last_o  = mean_last_q;
  assign bus.mean_size_o  = size_q;
  assign bus.r_o          = r_q;
  assign bus.g_o          = g_q;
  assign bus.b_o          = b_q;

endmodule

// File: tb/tb_mean_frame_ctrl.sv
// Self-checking bench for mean_frame_ctrl. Plays the pixel source, a small
// behavioural Mean stage (sums cleared by mean_rst_n_o) and the AWB sink;
// expected means come from plain averages of the generated frame.
module tb_mean_frame_ctrl;

  localparam int CLR_CYC     = 2;
  localparam int TIMEOUT_CYC = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mean_frame_ctrl_if bus ();

  mean_frame_ctrl #(
    .SIZE_MAX    (20),
    .CLR_CYC     (CLR_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  byte unsigned pix_q[$];
  logic [1:0]   beat_color[$];
  logic [7:0]   beat_value[$];
  logic         beat_last[$];
  int           clr_low  = 0;
  int           done_cnt = 0;
  int           err_cnt  = 0;
  int unsigned  mean_sum[3];

  // Observe the Mean link 2 ns after each rising edge: record beats,
  // accumulate per-colour sums like Mean would, count pulses.
  always begin
    @(posedge clk);
    #2;
    if (!bus.mean_rst_n_o) begin
      clr_low++;
      for (int c = 0; c < 3; c++) mean_sum[c] = 0;
    end else if (bus.mean_valid_o) begin
      beat_color.push_back(bus.mean_color_o);
      beat_value.push_back(bus.mean_value_o);
      beat_last.push_back(bus.mean_last_o);
      if (bus.mean_color_o < 2'd3) mean_sum[bus.mean_color_o] += 32'(bus.mean_value_o);
    end
    if (bus.done_o) done_cnt++;
    if (bus.err_o) err_cnt++;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Plain average of one plane of the generated frame.
  function automatic logic [7:0] model_mean(input int plane, input int sz);
    int n = 1 << sz;
    int unsigned sum = 0;
    for (int i = 0; i < n; i++) sum += pix_q[plane * n + i];
    return 8'(sum >> sz);
  endfunction

  function automatic void make_frame(input int sz, input int r_fix, input int g_fix, input int b_fix);
    int n = 1 << sz;
    int fix[3];
    fix[0] = r_fix; fix[1] = g_fix; fix[2] = b_fix;
    pix_q.delete();
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < n; i++)
        pix_q.push_back((fix[p] < 0) ? 8'($urandom) : 8'(fix[p]));
  endfunction

  task automatic start_frame(input logic [4:0] sz);
    @(negedge clk);
    beat_color.delete(); beat_value.delete(); beat_last.delete();
    clr_low        = 0;
    bus.start_i    = 1'b1;
    bus.size_i     = sz;
    @(negedge clk);
    bus.start_i    = 1'b0;
  endtask

  // Push up to max_xfer pixels of pix_q; a pixel counts only when ready was high.
  task automatic apply_stimulus(input bit gaps, input int max_xfer, output int sent);
    int idx    = 0;
    int budget = 0;
    int limit  = (max_xfer < pix_q.size()) ? max_xfer : pix_q.size();
    bit v;
    while (idx < limit && budget < 5000) begin
      @(negedge clk);
      budget++;
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.pix_valid_i = v;
      bus.pix_value_i = v ? pix_q[idx] : 8'($urandom);
      #1;
      if (v && bus.pix_ready_o) idx++;
    end
    @(negedge clk);
    bus.pix_valid_i = 1'b0;
    sent = idx;
  endtask

  task automatic finish_frame(input int sz, input int drain_wait, input string tag);
    int n     = 1 << sz;
    int total = 3 * n;
    int waitc = 0;
    int bad   = 0;
    int done0;
    logic [23:0] exp_rgb;
    while (beat_value.size() < total && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    check_output({tag, "_beats"}, beat_value.size(), total);
    for (int i = 0; i < beat_value.size() && i < total; i++) begin
      if (beat_color[i] !== 2'(i / n) || beat_value[i] !== pix_q[i] ||
          beat_last[i] !== ((i % n) == n - 1)) bad++;
    end
    check_output({tag, "_beat_content_errors"}, bad, 0);
    check_output({tag, "_drain_busy_ready"}, {bus.busy_o, bus.pix_ready_o}, 2'b10);
    repeat (drain_wait) @(negedge clk);
    check_output({tag, "_drain_no_err"}, err_cnt, 0);
    check_output({tag, "_still_draining"}, bus.busy_o, 1'b1);
    done0 = done_cnt;
    exp_rgb = {model_mean(0, sz), model_mean(1, sz), model_mean(2, sz)};
    bus.mean_finish_i = 1'b1;
    bus.r_mean_i = 8'(mean_sum[0] >> bus.mean_size_o);
    bus.g_mean_i = 8'(mean_sum[1] >> bus.mean_size_o);
    bus.b_mean_i = 8'(mean_sum[2] >> bus.mean_size_o);
    @(negedge clk);
    bus.mean_finish_i = 1'b0;
    bus.r_mean_i = 8'($urandom); bus.g_mean_i = 8'($urandom); bus.b_mean_i = 8'($urandom);
    check_output({tag, "_done"}, bus.done_o, 1'b1);
    check_output({tag, "_rgb"}, {bus.r_o, bus.g_o, bus.b_o}, exp_rgb);
    @(negedge clk);
    check_output({tag, "_done_busy_after"}, {bus.done_o, bus.busy_o}, 2'b00);
    check_output({tag, "_rgb_held"}, {bus.r_o, bus.g_o, bus.b_o}, exp_rgb);
    check_output({tag, "_one_done"}, done_cnt - done0, 1);
  endtask

  int          sent;
  int          k;
  int          done_before;
  logic [23:0] rgb_before;

  // Directed sequence of frames with randomized pixel data and gaps.
  initial begin
    bus.start_i = 0; bus.abort_i = 0; bus.size_i = 0;
    bus.pix_valid_i = 0; bus.pix_value_i = 0;
    bus.mean_finish_i = 0; bus.r_mean_i = 0; bus.g_mean_i = 0; bus.b_mean_i = 0;

    repeat (2) @(negedge clk);
    check_output("reset_mean_rst_n", bus.mean_rst_n_o, 1'b0);
    check_output("reset_flags", {bus.busy_o, bus.pix_ready_o, bus.mean_valid_o, bus.done_o, bus.err_o}, 5'b0);
    check_output("reset_rgb", {bus.r_o, bus.g_o, bus.b_o}, 24'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("release_mean_rst_n", bus.mean_rst_n_o, 1'b1);

    $display("[TB] frame 1: size 2, constant planes, no gaps");
    make_frame(2, 8, 16, 255);
    start_frame(5'd2);
    apply_stimulus(1'b0, 1000, sent);
    check_output("t1_sent", sent, 12);
    check_output("t1_clr_cycles", clr_low, CLR_CYC);
    finish_frame(2, 3, "t1");
    check_output("t1_rgb_const", {bus.r_o, bus.g_o, bus.b_o}, {8'd8, 8'd16, 8'd255});

    $display("[TB] frame 2: same frame with random valid gaps");
    start_frame(5'd2);
    apply_stimulus(1'b1, 1000, sent);
    finish_frame(2, 0, "t2");

    $display("[TB] frames 3a/3b: back-to-back, size 1");
    make_frame(1, 100, -1, -1);
    start_frame(5'd1);
    apply_stimulus(1'b0, 1000, sent);
    check_output("t3a_clr_cycles", clr_low, CLR_CYC);
    finish_frame(1, 1, "t3a");
    make_frame(1, 20, -1, -1);
    start_frame(5'd1);
    apply_stimulus(1'b1, 1000, sent);
    check_output("t3b_clr_cycles", clr_low, CLR_CYC);
    finish_frame(1, 1, "t3b");
    check_output("t3b_r_is_20", bus.r_o, 8'd20);

`ifndef MEAN_CTRL_TIMEOUT_EN
    $display("[TB] frame: size 3 random, long DRAIN wait");
    make_frame(3, -1, -1, -1);
    start_frame(5'd3);
    apply_stimulus(1'b1, 1000, sent);
    finish_frame(3, TIMEOUT_CYC + 16, "tlong");
`endif

    $display("[TB] abort after 5 of 12 pixels");
    rgb_before  = {bus.r_o, bus.g_o, bus.b_o};
    done_before = done_cnt;
    make_frame(2, -1, -1, -1);
    start_frame(5'd2);
    apply_stimulus(1'b0, 5, sent);
    bus.abort_i = 1'b1;
    bus.pix_valid_i = 1'b1;
    #1;
    check_output("t4_ready_on_abort", bus.pix_ready_o, 1'b0);
    @(negedge clk);
    bus.abort_i = 1'b0;
    bus.pix_valid_i = 1'b0;
    k = 0;
    while (bus.busy_o && k < 50) begin @(negedge clk); k++; end
    check_output("t4_idle", bus.busy_o, 1'b0);
    check_output("t4_beats", beat_value.size(), 5);
    check_output("t4_clr_cycles", clr_low, 2 * CLR_CYC);
    check_output("t4_no_done", done_cnt, done_before);
    check_output("t4_rgb_kept", {bus.r_o, bus.g_o, bus.b_o}, rgb_before);
    check_output("t4_mean_rst_n", bus.mean_rst_n_o, 1'b1);

    $display("[TB] idle: finish and abort are ignored");
    @(negedge clk);
    bus.mean_finish_i = 1'b1; bus.abort_i = 1'b1;
    bus.r_mean_i = ~rgb_before[23:16]; bus.g_mean_i = ~rgb_before[15:8]; bus.b_mean_i = ~rgb_before[7:0];
    @(negedge clk);
    bus.mean_finish_i = 1'b0; bus.abort_i = 1'b0;
    check_output("idle_rgb_kept", {bus.r_o, bus.g_o, bus.b_o}, rgb_before);
    check_output("idle_busy_rstn", {bus.busy_o, bus.mean_rst_n_o, bus.done_o}, 3'b010);

    $display("[TB] size 21 rejected, size 0 frame");
    err_cnt = 0;
    @(negedge clk);
    bus.start_i = 1'b1; bus.size_i = 5'd21;
    @(negedge clk);
    bus.start_i = 1'b0;
    check_output("t5_err_pulse", {bus.err_o, bus.busy_o}, 2'b10);
    @(negedge clk);
    check_output("t5_err_cleared", {bus.err_o, bus.busy_o}, 2'b00);
    check_output("t5_err_count", err_cnt, 1);
    err_cnt = 0;
    make_frame(0, -1, -1, -1);
    start_frame(5'd0);
    apply_stimulus(1'b1, 1000, sent);
    finish_frame(0, 0, "t5");

`ifdef MEAN_CTRL_TIMEOUT_EN
    $display("[TB] DRAIN watchdog, finish never arrives");
    rgb_before  = {bus.r_o, bus.g_o, bus.b_o};
    done_before = done_cnt;
    make_frame(1, -1, -1, -1);
    start_frame(5'd1);
    apply_stimulus(1'b0, 1000, sent);
    k = 0;
    while (!bus.err_o && k < 4 * TIMEOUT_CYC) begin @(negedge clk); k++; end
    check_output("t6_err_cycle", k, TIMEOUT_CYC);
    k = 0;
    while (bus.busy_o && k < 50) begin @(negedge clk); k++; end
    check_output("t6_idle", bus.busy_o, 1'b0);
    check_output("t6_no_done", done_cnt, done_before);
    check_output("t6_rgb_kept", {bus.r_o, bus.g_o, bus.b_o}, rgb_before);
`endif

    $display("[TB] async reset mid-frame");
    make_frame(2, -1, -1, -1);
    start_frame(5'd2);
    apply_stimulus(1'b0, 3, sent);
    rst_n = 1'b0;
    #1;
    check_output("arst_state", {bus.mean_rst_n_o, bus.busy_o, bus.pix_ready_o, bus.mean_valid_o}, 4'b0000);
    check_output("arst_rgb", {bus.r_o, bus.g_o, bus.b_o}, 24'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("arst_release", {bus.mean_rst_n_o, bus.busy_o}, 2'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
